u_lsu: RTL and testbench

Load/store unit sitting directly downstream of the execute stage. It accepts one memory access per request from the execute stage's registered LSU outputs, performs byte-lane alignment, drives a request/grant/response data bus, and returns load data (sign- or zero-extended) with a one-cycle valid pulse. While an access is outstanding it raises a busy/stall signal to the hazard logic. It also reports misaligned, malformed, bus-error and timeout conditions.

---
 rtl/u_lsu_if.sv | 39 +++
 rtl/u_lsu.sv | 259 +++++++++++++++++++++++++
 tb/tb_u_lsu.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/u_lsu_if.sv
// ----------------------------------------------------------------------------
// u_lsu_if : data-bus bundle between the load/store unit and the memory side.
//
// Signals
//   dbus_req   LSU -> mem  bus request, held until dbus_gnt
//   dbus_we    LSU -> mem  1 = write, 0 = read
//   dbus_be    LSU -> mem  byte enables, already shifted to the byte lane
//   dbus_adr   LSU -> mem  word-aligned address
//   dbus_wdat  LSU -> mem  write data, already shifted to the byte lane
//   dbus_gnt   mem -> LSU  request accepted this cycle
//   dbus_rvld  mem -> LSU  read data valid
//   dbus_rdat  mem -> LSU  full read word
//   dbus_err   mem -> LSU  bus error, qualified by gnt (write) or rvld (read)
//
// Modports
//   master : the load/store unit side
//   slave  : the memory / interconnect side
// ----------------------------------------------------------------------------
interface u_lsu_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_adr;
    logic [31:0] dbus_wdat;
    logic        dbus_gnt;
    logic        dbus_rvld;
    logic [31:0] dbus_rdat;
    logic        dbus_err;

    modport master (
        output dbus_req, dbus_we, dbus_be, dbus_adr, dbus_wdat,
        input  dbus_gnt, dbus_rvld, dbus_rdat, dbus_err
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_be, dbus_adr, dbus_wdat,
        output dbus_gnt, dbus_rvld, dbus_rdat, dbus_err
    );
endinterface

// File: rtl/u_lsu.sv
// ----------------------------------------------------------------------------
// u_lsu : load/store unit downstream of the execute stage.
//
// Accepts one access at a time from execute, aligns it onto the byte lanes of
// a request/grant/response data bus, and returns a one-cycle completion pulse
// with sign/zero-extended load data. Malformed size masks and misaligned
// accesses complete immediately with an error and never touch the bus. A
// per-access timeout aborts accesses that are not granted or not answered.
//
// Parameters
//   TIMEOUT_CYC  cycles allowed in REQ or WAIT_R before abort (2..255)
//
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   i_lsu_a        byte address
//   i_lsu_we       store size mask (0001 byte, 0011 half, 1111 word), unshifted
//   i_lsu_wd       store data in the low bytes
//   i_lsu_re       load size mask, same encoding
//   i_lsu_uns      load is unsigned
//   o_lsu_vld      one-cycle completion pulse
//   o_lsu_rd       extended load data, held until the next successful load
//   o_lsu_err      error qualifier for o_lsu_vld
//   o_lsu_busy     stall request (access in flight)
//   dbus           data bus, master side (see u_lsu_if)
// ----------------------------------------------------------------------------
module u_lsu #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_lsu_a,
    input  logic [3:0]  i_lsu_we,
    input  logic [31:0] i_lsu_wd,
    input  logic [3:0]  i_lsu_re,
    input  logic        i_lsu_uns,
    output logic        o_lsu_vld,
    output logic [31:0] o_lsu_rd,
    output logic        o_lsu_err,
    output logic        o_lsu_busy,
    u_lsu_if.master     dbus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Counter value in the last permitted cycle; reaching it without the
    // awaited event ends the access on the following edge.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 32'd1);

    // Only byte, half and word masks are legal.
    function automatic logic f_mask_ok(input logic [3:0] mask);
        logic ok;
        case (mask)
            4'b0001, 4'b0011, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halves need a[0]==0, words need a[1:0]==0; bytes are always aligned.
    function automatic logic f_misaligned(input logic [3:0] mask, input logic [1:0] ofs);
        logic mis;
        case (mask)
            4'b0011: mis = ofs[0];
            4'b1111: mis = (ofs != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Bring the addressed lane down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] f_load_ext(input logic [31:0] rdat,
                                               input logic [1:0]  ofs,
                                               input logic [3:0]  mask,
                                               input logic        uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdat >> {ofs, 3'b000};
        case (mask)
            4'b0001: res = {{24{~uns & sh[7]}},  sh[7:0]};
            4'b0011: res = {{16{~uns & sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    state_e      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_ofs;
    logic [3:0]  r_mask;
    logic        r_uns;
    logic        r_is_store;
    logic        r_lsu_vld;
    logic [31:0] r_lsu_rd;
    logic        r_lsu_err;
    logic        r_lsu_busy;
    logic        r_dbus_req;
    logic        r_dbus_we;
    logic [3:0]  r_dbus_be;
    logic [31:0] r_dbus_adr;
    logic [31:0] r_dbus_wdat;

    logic        w_is_store;
    logic        w_capture;
    logic [3:0]  w_mask;
    logic        w_fault;
    logic [3:0]  w_be;
    logic [31:0] w_wdat;
    logic        w_timeout;

    // Decode of the incoming execute request; a store wins over a load.
    always_comb begin
        w_is_store = (i_lsu_we != 4'b0000);
        w_capture  = w_is_store || (i_lsu_re != 4'b0000);
        w_mask     = w_is_store ? i_lsu_we : i_lsu_re;
        w_fault    = !f_mask_ok(w_mask) || f_misaligned(w_mask, i_lsu_a[1:0]);
        w_be       = w_mask << i_lsu_a[1:0];
        w_wdat     = w_is_store ? (i_lsu_wd << {i_lsu_a[1:0], 3'b000}) : 32'h0000_0000;
        w_timeout  = (r_cnt == TO_LAST);
    end

    // Access sequencer: state, timeout counter, latched request and all
    // registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_ofs       <= 2'b00;
            r_mask      <= 4'b0000;
            r_uns       <= 1'b0;
            r_is_store  <= 1'b0;
            r_lsu_vld   <= 1'b0;
            r_lsu_rd    <= 32'h0000_0000;
            r_lsu_err   <= 1'b0;
            r_lsu_busy  <= 1'b0;
            r_dbus_req  <= 1'b0;
            r_dbus_we   <= 1'b0;
            r_dbus_be   <= 4'b0000;
            r_dbus_adr  <= 32'h0000_0000;
            r_dbus_wdat <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_lsu_vld <= 1'b0;
                    r_lsu_err <= 1'b0;
                    if (w_capture) begin
                        r_ofs      <= i_lsu_a[1:0];
                        r_mask     <= w_mask;
                        r_uns      <= i_lsu_uns;
                        r_is_store <= w_is_store;
                        r_lsu_busy <= 1'b1;
                        if (w_fault) begin
                            // Report immediately; the bus never sees it.
                            r_state   <= ST_RESP;
                            r_lsu_vld <= 1'b1;
                            r_lsu_err <= 1'b1;
                        end else begin
                            r_state     <= ST_REQ;
                            r_cnt       <= 8'd0;
                            r_dbus_req  <= 1'b1;
                            r_dbus_we   <= w_is_store;
                            r_dbus_be   <= w_be;
                            r_dbus_adr  <= {i_lsu_a[31:2], 2'b00};
                            r_dbus_wdat <= w_wdat;
                        end
                    end else begin
                        r_lsu_busy <= 1'b0;
                    end
                end

                ST_REQ: begin
                    if (dbus.dbus_gnt) begin
                        // Grant wins over a timeout in the same cycle.
                        r_cnt       <= 8'd0;
                        r_dbus_req  <= 1'b0;
                        r_dbus_we   <= 1'b0;
                        r_dbus_be   <= 4'b0000;
                        r_dbus_adr  <= 32'h0000_0000;
                        r_dbus_wdat <= 32'h0000_0000;
                        if (r_is_store) begin
                            r_state   <= ST_RESP;
                            r_lsu_vld <= 1'b1;
                            r_lsu_err <= dbus.dbus_err;
                        end else begin
                            r_state <= ST_WAIT_R;
                        end
                    end else if (w_timeout) begin
                        r_dbus_req  <= 1'b0;
                        r_dbus_we   <= 1'b0;
                        r_dbus_be   <= 4'b0000;
                        r_dbus_adr  <= 32'h0000_0000;
                        r_dbus_wdat <= 32'h0000_0000;
                        r_state     <= ST_RESP;
                        r_lsu_vld   <= 1'b1;
                        r_lsu_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ST_WAIT_R: begin
                    if (dbus.dbus_rvld) begin
                        r_state   <= ST_RESP;
                        r_lsu_vld <= 1'b1;
                        r_lsu_err <= dbus.dbus_err;
                        // A failed read leaves the previous load result visible.
                        if (!dbus.dbus_err) begin
                            r_lsu_rd <= f_load_ext(dbus.dbus_rdat, r_ofs, r_mask, r_uns);
                        end else begin
                            r_lsu_rd <= r_lsu_rd;
                        end
                    end else if (w_timeout) begin
                        r_state   <= ST_RESP;
                        r_lsu_vld <= 1'b1;
                        r_lsu_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ST_RESP: begin
                    // Completion pulse lasts exactly this cycle; no capture here.
                    r_state    <= ST_IDLE;
                    r_lsu_vld  <= 1'b0;
                    r_lsu_err  <= 1'b0;
                    r_lsu_busy <= 1'b0;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= 8'd0;
                    r_lsu_vld   <= 1'b0;
                    r_lsu_err   <= 1'b0;
                    r_lsu_busy  <= 1'b0;
                    r_dbus_req  <= 1'b0;
                    r_dbus_we   <= 1'b0;
                    r_dbus_be   <= 4'b0000;
                    r_dbus_adr  <= 32'h0000_0000;
                    r_dbus_wdat <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign o_lsu_vld      = r_lsu_vld;
    assign o_lsu_rd       = r_lsu_rd;
    assign o_lsu_err      = r_lsu_err;
    assign o_lsu_busy     = r_lsu_busy;
    assign dbus.dbus_req  = r_dbus_req;
    assign dbus.dbus_we   = r_dbus_we;
    assign dbus.dbus_be   = r_dbus_be;
    assign dbus.dbus_adr  = r_dbus_adr;
    assign dbus.dbus_wdat = r_dbus_wdat;

endmodule

// File: tb/tb_u_lsu.sv
// ----------------------------------------------------------------------------
// tb_u_lsu : self-checking bench for u_lsu.
// A table of directed accesses with hand-computed results, a few hand-written
// multi-cycle sequences (late read data, reset mid-access), then random
// accesses checked against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_u_lsu;

    localparam int T = 16;

    logic        clk;
    logic        rstn;
    logic [31:0] lsu_a;
    logic [3:0]  lsu_we;
    logic [31:0] lsu_wd;
    logic [3:0]  lsu_re;
    logic        lsu_uns;
    logic        lsu_vld;
    logic [31:0] lsu_rd;
    logic        lsu_err;
    logic        lsu_busy;

    u_lsu_if bus();

    u_lsu #(.TIMEOUT_CYC(T)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_lsu_a   (lsu_a),
        .i_lsu_we  (lsu_we),
        .i_lsu_wd  (lsu_wd),
        .i_lsu_re  (lsu_re),
        .i_lsu_uns (lsu_uns),
        .o_lsu_vld (lsu_vld),
        .o_lsu_rd  (lsu_rd),
        .o_lsu_err (lsu_err),
        .o_lsu_busy(lsu_busy),
        .dbus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus (a..berr) and expected/observed results (e_*).
    // gd   : REQ cycles before the bench grants (>= T means never)
    // rdly : WAIT_R cycles before read data (>= T means never)
    typedef struct {
        logic [31:0] a;
        logic [3:0]  we;
        logic [31:0] wd;
        logic [3:0]  re;
        logic        uns;
        int          gd;
        int          rdly;
        logic [31:0] rdat;
        logic        berr;
        int          e_reqc;
        logic [3:0]  e_be;
        logic [31:0] e_adr;
        logic [31:0] e_wdat;
        logic        e_we;
        int          e_lat;
        logic        e_err;
        logic [31:0] e_rd;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_rd;
    vec_t        tbl[17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference behaviour straight from the access rules.
    function automatic vec_t model(input vec_t v, input logic [31:0] prev_rd);
        vec_t        o;
        bit          st;
        logic [3:0]  m;
        int          size;
        int          ofs;
        logic [31:0] sh;
        logic [31:0] lim;
        logic [31:0] val;
        o = v;
        st = (v.we != 4'd0);
        m = st ? v.we : v.re;
        size = (m == 4'b0001) ? 1 : (m == 4'b0011) ? 2 : (m == 4'b1111) ? 4 : 0;
        ofs = int'(v.a % 32'd4);
        o.e_reqc = 0; o.e_be = 4'd0; o.e_adr = 32'd0; o.e_wdat = 32'd0; o.e_we = 1'b0;
        o.e_rd = prev_rd;
        if (size == 0 || (ofs % size) != 0) begin
            o.e_lat = 1; o.e_err = 1'b1;
            return o;
        end
        o.e_be   = 4'((32'(m) << ofs) & 32'hF);
        o.e_adr  = v.a - 32'(ofs);
        o.e_wdat = st ? (v.wd << (8 * ofs)) : 32'd0;
        o.e_we   = st;
        if (v.gd >= T) begin
            o.e_reqc = T; o.e_lat = T + 1; o.e_err = 1'b1;
            return o;
        end
        o.e_reqc = v.gd + 1;
        if (st) begin
            o.e_lat = v.gd + 2; o.e_err = v.berr;
        end else if (v.rdly >= T) begin
            o.e_lat = v.gd + 2 + T; o.e_err = 1'b1;
        end else begin
            o.e_lat = v.gd + 3 + v.rdly; o.e_err = v.berr;
            if (!v.berr) begin
                sh = v.rdat >> (8 * ofs);
                if (size == 4) begin
                    val = sh;
                end else begin
                    lim = 32'd1 << (8 * size);
                    val = sh % lim;
                    if (!v.uns && val >= (lim >> 1)) val = val + (32'hFFFF_FFFF - lim + 32'd1);
                end
                o.e_rd = val;
            end
        end
        return o;
    endfunction

    // Drive one access from an IDLE cycle, act as the memory, observe outputs.
    task automatic run_access(input vec_t v, output vec_t ob,
                              output bit s_ok, output bit b_ok, output bit p_ok);
        int n = 0;
        int req_seen = 0;
        int wait_n = 0;
        bit gnt_done = 0;
        bit done = 0;
        bit st;
        ob = v;
        ob.e_reqc = 0; ob.e_be = 4'd0; ob.e_adr = 32'd0; ob.e_wdat = 32'd0; ob.e_we = 1'b0;
        ob.e_lat = -1; ob.e_err = 1'b0; ob.e_rd = 32'd0;
        s_ok = 1; b_ok = 1; p_ok = 1;
        st = (v.we != 4'd0);
        lsu_a = v.a; lsu_we = v.we; lsu_wd = v.wd; lsu_re = v.re; lsu_uns = v.uns;
        while (!done && n < 400) begin
            @(posedge clk); #1;
            n++;
            bus.dbus_gnt = 1'b0; bus.dbus_rvld = 1'b0; bus.dbus_err = 1'b0;
            if (lsu_busy !== 1'b1) b_ok = 0;
            if (lsu_vld === 1'b1) begin
                ob.e_lat = n; ob.e_err = lsu_err; ob.e_rd = lsu_rd;
                done = 1;
            end else if (bus.dbus_req === 1'b1) begin
                if (req_seen == 0) begin
                    ob.e_be = bus.dbus_be; ob.e_adr = bus.dbus_adr;
                    ob.e_wdat = bus.dbus_wdat; ob.e_we = bus.dbus_we;
                end else if ({bus.dbus_we, bus.dbus_be, bus.dbus_adr, bus.dbus_wdat} !==
                             {ob.e_we, ob.e_be, ob.e_adr, ob.e_wdat}) begin
                    s_ok = 0;
                end
                req_seen++;
                if (req_seen == v.gd + 1) begin
                    bus.dbus_gnt = 1'b1;
                    bus.dbus_err = st ? v.berr : 1'b0;
                    gnt_done = 1;
                end
            end else if (gnt_done && !st) begin
                if (wait_n == v.rdly) begin
                    bus.dbus_rvld = 1'b1; bus.dbus_rdat = v.rdat; bus.dbus_err = v.berr;
                end
                wait_n++;
            end
        end
        ob.e_reqc = req_seen;
        lsu_we = 4'd0; lsu_re = 4'd0;
        bus.dbus_gnt = 1'b0; bus.dbus_rvld = 1'b0; bus.dbus_err = 1'b0;
        @(posedge clk); #1;
        if (lsu_vld !== 1'b0 || lsu_busy !== 1'b0) p_ok = 0;
        if (!done) begin
            $display("FAIL access_bound: actual=no completion required=completion within 400 cycles");
            rstn = 1'b0; #1; rstn = 1'b1;
            model_rd = 32'd0;
        end
    endtask

    task automatic compare(input string tag, input vec_t e, input vec_t ob,
                           input bit s_ok, input bit b_ok, input bit p_ok);
        check({tag, ".reqc"}, 32'(ob.e_reqc), 32'(e.e_reqc));
        if (e.e_reqc != 0) begin
            check({tag, ".be"},   32'(ob.e_be), 32'(e.e_be));
            check({tag, ".adr"},  ob.e_adr, e.e_adr);
            check({tag, ".wdat"}, ob.e_wdat, e.e_wdat);
            check({tag, ".we"},   32'(ob.e_we), 32'(e.e_we));
            check({tag, ".stable"}, 32'(s_ok), 32'd1);
        end
        check({tag, ".lat"},   32'(ob.e_lat), 32'(e.e_lat));
        check({tag, ".err"},   32'(ob.e_err), 32'(e.e_err));
        check({tag, ".rd"},    ob.e_rd, e.e_rd);
        check({tag, ".busy"},  32'(b_ok), 32'd1);
        check({tag, ".pulse"}, 32'(p_ok), 32'd1);
    endtask

    initial begin
        vec_t ob;
        vec_t rv;
        vec_t ex;
        bit   s_ok, b_ok, p_ok;
        logic [3:0] pool [9];

        //          a            we     wd            re     uns gd   rdly rdat          berr reqc be     adr           wdat          we   lat err   rd
        tbl[0]  = '{32'h100, 4'hF, 32'hDEADBEEF, 4'h0, 1'b0, 0,   0,   32'h0,        1'b0, 1,   4'hF, 32'h100, 32'hDEADBEEF, 1'b1, 2,  1'b0, 32'h0};
        tbl[1]  = '{32'h103, 4'h0, 32'h0,        4'h1, 1'b0, 0,   1,   32'h80000000, 1'b0, 1,   4'h8, 32'h100, 32'h0,        1'b0, 4,  1'b0, 32'hFFFFFF80};
        tbl[2]  = '{32'h103, 4'h0, 32'h0,        4'h1, 1'b1, 0,   1,   32'h80000000, 1'b0, 1,   4'h8, 32'h100, 32'h0,        1'b0, 4,  1'b0, 32'h00000080};
        tbl[3]  = '{32'h202, 4'h3, 32'h1234,     4'h0, 1'b0, 0,   0,   32'h0,        1'b0, 1,   4'hC, 32'h200, 32'h12340000, 1'b1, 2,  1'b0, 32'h00000080};
        tbl[4]  = '{32'h201, 4'h0, 32'h0,        4'h3, 1'b0, 0,   0,   32'h0,        1'b0, 0,   4'h0, 32'h0,   32'h0,        1'b0, 1,  1'b1, 32'h00000080};
        tbl[5]  = '{32'h300, 4'h0, 32'h0,        4'hF, 1'b0, 5,   0,   32'h89ABCDEF, 1'b0, 6,   4'hF, 32'h300, 32'h0,        1'b0, 8,  1'b0, 32'h89ABCDEF};
        tbl[6]  = '{32'h400, 4'hF, 32'h11223344, 4'h0, 1'b0, 255, 0,   32'h0,        1'b0, 16,  4'hF, 32'h400, 32'h11223344, 1'b1, 17, 1'b1, 32'h89ABCDEF};
        tbl[7]  = '{32'h404, 4'h0, 32'h0,        4'hF, 1'b0, 0,   0,   32'hFFFFFFFF, 1'b1, 1,   4'hF, 32'h404, 32'h0,        1'b0, 3,  1'b1, 32'h89ABCDEF};
        tbl[8]  = '{32'h500, 4'hF, 32'hCAFEF00D, 4'hF, 1'b0, 0,   0,   32'h0,        1'b0, 1,   4'hF, 32'h500, 32'hCAFEF00D, 1'b1, 2,  1'b0, 32'h89ABCDEF};
        tbl[9]  = '{32'h600, 4'h0, 32'h0,        4'h5, 1'b0, 0,   0,   32'h0,        1'b0, 0,   4'h0, 32'h0,   32'h0,        1'b0, 1,  1'b1, 32'h89ABCDEF};
        tbl[10] = '{32'h102, 4'h0, 32'h0,        4'h3, 1'b0, 0,   0,   32'h80011234, 1'b0, 1,   4'hC, 32'h100, 32'h0,        1'b0, 3,  1'b0, 32'hFFFF8001};
        tbl[11] = '{32'h000, 4'h0, 32'h0,        4'h3, 1'b1, 0,   0,   32'hABCDF00F, 1'b0, 1,   4'h3, 32'h0,   32'h0,        1'b0, 3,  1'b0, 32'h0000F00F};
        tbl[12] = '{32'h007, 4'h1, 32'hA5,       4'h0, 1'b0, 0,   0,   32'h0,        1'b0, 1,   4'h8, 32'h4,   32'hA5000000, 1'b1, 2,  1'b0, 32'h0000F00F};
        tbl[13] = '{32'h010, 4'hF, 32'h1,        4'h0, 1'b0, 2,   0,   32'h0,        1'b1, 3,   4'hF, 32'h10,  32'h1,        1'b1, 4,  1'b1, 32'h0000F00F};
        tbl[14] = '{32'h020, 4'h0, 32'h0,        4'hF, 1'b0, 0,   255, 32'h0,        1'b0, 1,   4'hF, 32'h20,  32'h0,        1'b0, 18, 1'b1, 32'h0000F00F};
        tbl[15] = '{32'h000, 4'h2, 32'h0,        4'h0, 1'b0, 0,   0,   32'h0,        1'b0, 0,   4'h0, 32'h0,   32'h0,        1'b0, 1,  1'b1, 32'h0000F00F};
        tbl[16] = '{32'h002, 4'h0, 32'h0,        4'h1, 1'b0, 0,   0,   32'h007F0000, 1'b0, 1,   4'h4, 32'h0,   32'h0,        1'b0, 3,  1'b0, 32'h0000007F};

        rstn = 1'b0;
        lsu_a = 32'd0; lsu_we = 4'd0; lsu_wd = 32'd0; lsu_re = 4'd0; lsu_uns = 1'b0;
        bus.dbus_gnt = 1'b0; bus.dbus_rvld = 1'b0; bus.dbus_rdat = 32'd0; bus.dbus_err = 1'b0;
        model_rd = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.vld",  32'(lsu_vld), 32'd0);
        check("rst.err",  32'(lsu_err), 32'd0);
        check("rst.busy", 32'(lsu_busy), 32'd0);
        check("rst.rd",   lsu_rd, 32'd0);
        check("rst.req",  32'(bus.dbus_req), 32'd0);
        check("rst.bus",  {bus.dbus_adr[27:0], bus.dbus_be}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 17; i++) begin
            run_access(tbl[i], ob, s_ok, b_ok, p_ok);
            compare($sformatf("v%0d", i), tbl[i], ob, s_ok, b_ok, p_ok);
            model_rd = tbl[i].e_rd;
        end

        // Read data showing up while idle must be ignored.
        for (int k = 0; k < 3; k++) begin
            bus.dbus_rvld = 1'b1; bus.dbus_rdat = 32'h12345678;
            @(posedge clk); #1;
            check($sformatf("late_rvld%0d.vld", k),  32'(lsu_vld), 32'd0);
            check($sformatf("late_rvld%0d.busy", k), 32'(lsu_busy), 32'd0);
            check($sformatf("late_rvld%0d.rd", k),   lsu_rd, model_rd);
        end
        bus.dbus_rvld = 1'b0;

        // Reset while a load waits for its data.
        lsu_a = 32'h40; lsu_re = 4'hF; lsu_uns = 1'b0;
        @(posedge clk); #1;
        check("mid_rst.req", 32'(bus.dbus_req), 32'd1);
        bus.dbus_gnt = 1'b1;
        @(posedge clk); #1;
        bus.dbus_gnt = 1'b0;
        check("mid_rst.busy_pre", 32'(lsu_busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst.busy", 32'(lsu_busy), 32'd0);
        check("mid_rst.rd",   lsu_rd, 32'd0);
        check("mid_rst.vld",  32'(lsu_vld), 32'd0);
        check("mid_rst.req",  32'(bus.dbus_req), 32'd0);
        lsu_re = 4'd0;
        @(negedge clk);
        rstn = 1'b1;
        model_rd = 32'd0;
        @(posedge clk); #1;
        check("post_rst.busy", 32'(lsu_busy), 32'd0);

        // Random accesses against the reference model.
        pool = '{4'h1, 4'h3, 4'hF, 4'h1, 4'h3, 4'hF, 4'h5, 4'h2, 4'hC};
        for (int r = 0; r < 200; r++) begin
            rv = tbl[0];
            if ($urandom_range(0, 1) == 1) begin
                rv.we = pool[$urandom_range(0, 8)];
                rv.re = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 8)] : 4'h0;
            end else begin
                rv.we = 4'h0;
                rv.re = pool[$urandom_range(0, 8)];
            end
            rv.a    = $urandom;
            rv.wd   = $urandom;
            rv.rdat = $urandom;
            rv.uns  = 1'($urandom_range(0, 1));
            rv.gd   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
            rv.rdly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
            rv.berr = ($urandom_range(0, 7) == 0);
            ex = model(rv, model_rd);
            run_access(rv, ob, s_ok, b_ok, p_ok);
            compare($sformatf("r%0d", r), ex, ob, s_ok, b_ok, p_ok);
            model_rd = ex.e_rd;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
